// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares the TX FIFO write port between two byte producers
// (round-robin) and drains the FIFO into the UART transmitter one byte at a
// time using a tx_start / tx_done_tick handshake.
//
// Optional feature macro: UART_CTS_EN
//   defined   - a byte is popped only while cts_n=0 (checked in IDLE only)
//   undefined - sending is always permitted and cts_n is ignored
//
// Drain FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no byte in flight; pop the FIFO head when one is available
//   ST_START | tx_data holds the popped byte; tx_start pulses this cycle
//   ST_WAIT  | transmitter busy; leave on tx_done_tick

module uart_tx_sched #(
  parameter int B     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  input  logic [B-1:0]     req0_data,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [B-1:0]     req1_data,
  output logic             req1_ready,

  output logic             fifo_wr,
  output logic [B-1:0]     fifo_wr_data,
  input  logic             fifo_full,

  output logic             fifo_rd,
  input  logic [B-1:0]     fifo_rd_data,
  input  logic             fifo_empty,

  output logic             tx_start,
  output logic [B-1:0]     tx_data,
  input  logic             tx_done_tick,

  input  logic             cts_n,

  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic       rr;
  logic       grant0;
  logic       grant1;
  logic       send_ok;
  logic       pop;
  logic [1:0] state;
  logic [1:0] state_nxt;

  // Write arbiter: grant the lone requester, or the one rr points at when both ask.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !fifo_full) begin
      if (req0_valid && (!req1_valid || !rr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign fifo_wr      = grant0 | grant1;
  // With no grant the data is a don't-care, so req0 is passed through.
  assign fifo_wr_data = grant1 ? req1_data : req0_data;

  // Priority pointer moves past whoever was just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (grant0) begin
      rr <= 1'b1;
    end else if (grant1) begin
      rr <= 1'b0;
    end
  end

`ifdef UART_CTS_EN
  assign send_ok = ~cts_n;
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign send_ok    = 1'b1;
`endif

  // Pop only from IDLE, so at most one FIFO read per transmitted byte.
  assign pop     = !reset && (state == ST_IDLE) && !fifo_empty && send_ok;
  assign fifo_rd = pop;

  // Drain FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pop) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (tx_done_tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM registers: state, busy flag, start pulse, byte latch, sent-byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_count <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != ST_IDLE);
      // tx_start is high exactly in the cycle the FSM sits in START.
      tx_start <= pop;
      if (pop) begin
        tx_data <= fifo_rd_data;
      end
      if (state == ST_START) begin
        tx_count <= tx_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a small behavioural TX FIFO.
module tb_uart_tx_sched;

  localparam int B     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [B-1:0]     req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [B-1:0]     fifo_wr_data, fifo_rd_data;
  logic             tx_start, tx_done_tick, cts_n, busy;
  logic [B-1:0]     tx_data;
  logic [CNT_W-1:0] tx_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;

  uart_tx_sched #(.B(B), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_rd(fifo_rd), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
    .cts_n(cts_n), .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // 8-entry FIFO model; full_force lets a test hold the full flag high.
  logic [B-1:0] mem [0:7];
  logic [2:0]   wp = '0, rp = '0;
  logic [3:0]   cnt = '0;
  logic         full_force = 1'b0;
  logic         wr_ok, rd_ok;
  assign wr_ok        = fifo_wr && (cnt != 4'd8);
  assign rd_ok        = fifo_rd && (cnt != 4'd0);
  assign fifo_full    = (cnt == 4'd8) || full_force;
  assign fifo_empty   = (cnt == 4'd0);
  assign fifo_rd_data = mem[rp];

  always @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= fifo_wr_data;
      wp      <= wp + 3'd1;
    end
    if (rd_ok) rp <= rp + 3'd1;
    cnt <= cnt + {3'b0, wr_ok} - {3'b0, rd_ok};
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fifo_rd) rd_cnt <= rd_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b0; req1_data = 8'h00; tx_done_tick = 1'b0; cts_n = 1'b0;
    tick; tick;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || fifo_wr !== 1'b0)
      $display("FAIL reset_gate ready0=%b wr=%b required 0 0", req0_ready, fifo_wr);
    else n_pass++;
    tick;
    reset = 1'b0; req0_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || tx_count !== 16'd0 || tx_start !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_state busy=%b cnt=%0d start=%b data=%h required 0 0 0 00",
               busy, tx_count, tx_start, tx_data);
    else n_pass++;
  endtask

  task automatic test_drain;
    int rd_base, starts, since, s0, s1;
    logic [B-1:0] d0, d1;
    rd_base = rd_cnt; starts = 0; since = -1; s0 = 0; s1 = 0; d0 = '0; d1 = '0;
    req0_valid = 1'b1; req0_data = 8'h55;
    #1;
    n_checks++;
    if (fifo_wr !== 1'b1 || fifo_wr_data !== 8'h55 || fifo_rd !== 1'b0)
      $display("FAIL drain_load wr=%b data=%h rd=%b required 1 55 0", fifo_wr, fifo_wr_data, fifo_rd);
    else n_pass++;
    tick;
    req0_data = 8'hAA;
    #1;
    n_checks++;
    if (fifo_rd !== 1'b1 || fifo_wr !== 1'b1)
      $display("FAIL drain_pop_latency rd=%b wr=%b required 1 1", fifo_rd, fifo_wr);
    else n_pass++;
    tick;
    req0_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_start) begin
        if (starts == 0) begin s0 = cyc; d0 = tx_data; end
        else begin s1 = cyc; d1 = tx_data; end
        starts++;
        since = 0;
      end else if (starts > 0) begin
        since++;
      end
      tx_done_tick = (since == 10);
      tick;
    end
    tx_done_tick = 1'b0;
    n_checks++;
    if (starts !== 2) $display("FAIL drain_starts got %0d required 2", starts);
    else n_pass++;
    n_checks++;
    if (d0 !== 8'h55 || d1 !== 8'hAA)
      $display("FAIL drain_data got %h %h required 55 aa", d0, d1);
    else n_pass++;
    n_checks++;
    if (rd_cnt - rd_base !== 2) $display("FAIL drain_rd_count got %0d required 2", rd_cnt - rd_base);
    else n_pass++;
    n_checks++;
    if (tx_count !== 16'd2) $display("FAIL drain_tx_count got %0d required 2", tx_count);
    else n_pass++;
    n_checks++;
    if (s1 - s0 !== 12) $display("FAIL drain_spacing got %0d required 12", s1 - s0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL drain_idle busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    req1_valid = 1'b1; req1_data = 8'h3C;
    tick;
    req1_valid = 1'b0;
    tick; tick; tick;
    n_checks++;
    if (tx_count !== 16'd3 || busy !== 1'b1 || tx_data !== 8'h3C)
      $display("FAIL midwait_setup cnt=%0d busy=%b data=%h required 3 1 3c", tx_count, busy, tx_data);
    else n_pass++;
    reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h99;
    #1;
    n_checks++;
    if (fifo_rd !== 1'b0 || req0_ready !== 1'b0 || fifo_wr !== 1'b0)
      $display("FAIL midwait_gate rd=%b ready0=%b wr=%b required 0 0 0", fifo_rd, req0_ready, fifo_wr);
    else n_pass++;
    tick;
    reset = 1'b0; req0_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || tx_count !== 16'd0 || tx_start !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL midwait_reset busy=%b cnt=%0d start=%b data=%h required 0 0 0 00",
               busy, tx_count, tx_start, tx_data);
    else n_pass++;
  endtask

  task automatic test_arbitration;
    logic [B-1:0] d0_tab [4] = '{8'hA0, 8'hA1, 8'hA1, 8'hA2};
    logic [B-1:0] d1_tab [4] = '{8'hB0, 8'hB0, 8'hB1, 8'hB1};
    logic [B-1:0] exp_d  [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    logic         exp_r0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_data = d0_tab[k]; req1_data = d1_tab[k];
      #1;
      n_checks++;
      if (fifo_wr !== 1'b1 || fifo_wr_data !== exp_d[k] ||
          req0_ready !== exp_r0[k] || req1_ready !== !exp_r0[k])
        $display("FAIL arb_%0d wr=%b data=%h r0=%b r1=%b required 1 %h %b %b",
                 k, fifo_wr, fifo_wr_data, req0_ready, req1_ready, exp_d[k], exp_r0[k], !exp_r0[k]);
      else n_pass++;
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_full;
    int bad;
    bad = 0;
    full_force = 1'b1; req0_valid = 1'b1; req0_data = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (req0_ready !== 1'b0 || fifo_wr !== 1'b0) bad++;
      tick;
    end
    n_checks++;
    if (bad != 0) $display("FAIL full_block bad_cycles=%0d required 0", bad);
    else n_pass++;
    full_force = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || fifo_wr !== 1'b1 || fifo_wr_data !== 8'hC3)
      $display("FAIL full_release ready0=%b wr=%b data=%h required 1 1 c3", req0_ready, fifo_wr, fifo_wr_data);
    else n_pass++;
    tick;
    req0_valid = 1'b0;
  endtask

  task automatic drain_all;
    int left;
    left = 300;
    while (!(fifo_empty && !busy) && left > 0) begin
      tx_done_tick = busy;
      tick;
      left--;
    end
    tx_done_tick = 1'b0;
    tick;
    n_checks++;
    if (!(fifo_empty && !busy)) $display("FAIL drain_all_timeout empty=%b busy=%b required 1 0", fifo_empty, busy);
    else n_pass++;
  endtask

  task automatic test_stray_done;
    logic [CNT_W-1:0] c0;
    c0 = tx_count;
    tx_done_tick = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd !== 1'b0) $display("FAIL stray_rd rd=%b required 0", fifo_rd);
    else n_pass++;
    tick;
    tx_done_tick = 1'b0;
    tick;
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || tx_count !== c0)
      $display("FAIL stray_state busy=%b start=%b cnt=%0d required 0 0 %0d", busy, tx_start, tx_count, c0);
    else n_pass++;
  endtask

`ifdef UART_CTS_EN
  task automatic test_cts;
    int bad;
    bad = 0;
    cts_n = 1'b1; req0_valid = 1'b1; req0_data = 8'h77;
    tick;
    req0_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (fifo_rd !== 1'b0 || busy !== 1'b0) bad++;
      tick;
    end
    n_checks++;
    if (bad != 0) $display("FAIL cts_hold bad_cycles=%0d required 0", bad);
    else n_pass++;
    cts_n = 1'b0;
    #1;
    n_checks++;
    if (fifo_rd !== 1'b1) $display("FAIL cts_pop rd=%b required 1", fifo_rd);
    else n_pass++;
    tick;
    cts_n = 1'b1;
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h77)
      $display("FAIL cts_start start=%b data=%h required 1 77", tx_start, tx_data);
    else n_pass++;
    tick; tick;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL cts_no_abort busy=%b required 1", busy);
    else n_pass++;
    cts_n = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_drain;
    test_reset_mid_wait;
    test_arbitration;
    test_full;
    drain_all;
    test_stray_done;
`ifdef UART_CTS_EN
    test_cts;
    drain_all;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART. Shares one TX FIFO write port between two byte producers (req0: RX echo path, req1: status/message source) with round-robin arbitration, and drains the FIFO into the UART transmitter one byte at a time via a start/done handshake. It sits between the producers, the TX FIFO instance, and the transmitter, and is the only block that drives the FIFO `wr`/`rd` strobes.

## Interface
- B, 8, data width; must match the FIFO `B` and the transmitter data width
- CNT_W, 16, width of the transmitted-byte counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  producer 0 has a byte
- req0_data  in  B  producer 0 byte
- req0_ready  out  1  producer 0 byte accepted this cycle when high with req0_valid
- req1_valid, req1_data, req1_ready  same as req0 for producer 1
- fifo_wr  out  1  FIFO write strobe
- fifo_wr_data  out  B  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_rd  out  1  FIFO pop strobe
- fifo_rd_data  in  B  FIFO head byte; combinational, valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- tx_start  out  1  one-cycle pulse: transmitter loads tx_data
- tx_data  out  B  byte to transmit, registered
- tx_done_tick  in  1  one-cycle pulse from transmitter at end of stop bit
- cts_n  in  1  clear-to-send, active-low; used only with UART_CTS_EN
- busy  out  1  high while drain FSM is not IDLE
- tx_count  out  CNT_W  number of tx_start pulses since reset; wraps modulo 2^CNT_W

## Operation
- Write arbiter, combinational grant, registered priority pointer `rr`:
  - no grant while reset=1 or fifo_full=1; fifo_wr=0, both ready=0
  - one valid: grant it. Both valid: grant req0 if rr=0, req1 if rr=1
  - granted: readyX=1, fifo_wr=1, fifo_wr_data=reqX_data; rr <= index of granted + 1 (mod 2)
  - no grant: rr holds; fifo_wr_data=req0_data (don't-care)
  - producers must not make valid depend on ready; data must hold while valid && !ready
- Drain FSM, states IDLE, START, WAIT:
  - IDLE: if fifo_empty=0 and send permitted -> fifo_rd=1 (combinational, this cycle only), tx_data <= fifo_rd_data, go START
  - START: tx_start=1, tx_count <= tx_count+1, go WAIT
  - WAIT: on tx_done_tick -> IDLE; otherwise stay
  - tx_done_tick outside WAIT is ignored
- fifo_rd is never asserted when fifo_empty=1 or outside IDLE; at most one pop per transmitted byte
- Simultaneous fifo_wr and fifo_rd in the same cycle is legal and expected
- reset (any state, including mid-WAIT): state=IDLE, rr=0, tx_data=0, tx_start=0, tx_count=0, busy=0; fifo_wr, fifo_rd, ready forced 0 that cycle. A byte already popped and not yet sent is lost

## Timing
- Write: req accepted -> byte in FIFO at next edge; zero-cycle ready latency
- Drain: fifo_empty=0 seen in IDLE at cycle N -> fifo_rd at N, tx_start and valid tx_data at N+1, busy high from N+1
- Back-to-back: tx_done_tick at cycle M -> IDLE at M+1 -> next fifo_rd at M+1 earliest, tx_start at M+2
- Sustained fairness: with both producers continuously valid and FIFO not full, grants strictly alternate
- busy = (state != IDLE), registered

## Configuration
- UART_CTS_EN defined: send permitted only when cts_n=0, sampled in IDLE; deasserting cts_n in START/WAIT does not abort the byte in flight
- UART_CTS_EN undefined: send always permitted; cts_n ignored (port kept, unused)

## Test plan
- Reset mid-WAIT with tx_count=3 -> next cycle state IDLE, busy=0, tx_count=0, tx_start=0, no fifo_rd
- Both producers valid 4 cycles, FIFO not full, req0=0xA0.., req1=0xB0.. -> fifo_wr_data order A0,B0,A1,B1; ready alternates starting with req0
- fifo_full=1 with req0_valid=1 -> req0_ready=0, fifo_wr=0 until full drops; byte written the cycle full=0
- FIFO holds 0x55,0xAA; tx_done_tick 10 cycles after each start -> two tx_start pulses, tx_data 0x55 then 0xAA, exactly two fifo_rd pulses, tx_count=2, start-to-start spacing 12 cycles
- UART_CTS_EN, cts_n=1 with FIFO non-empty -> no fifo_rd for 20 cycles; cts_n->0 at cycle K -> fifo_rd at K, tx_start at K+1
- Stray tx_done_tick in IDLE with FIFO empty -> no state change, no fifo_rd
